// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key schedule and the encrypt stage.
// Contents:
//   byte_t / word_t / block_t : byte, 4-byte column word, 16-byte block
//   AES_NR                    : number of AES-128 rounds
//   RCON                      : round constants, index 1..10 (index 0 unused)
//   col_of / block_of         : conversion between the packed block layout and
//                               column words (row 0 in the most significant byte)
//   state_t                   : key-schedule FSM states
package aes_pkg;

    typedef logic [7:0]       byte_t;
    typedef logic [3:0][7:0]  word_t;
    typedef logic [15:0][7:0] block_t;

    localparam int AES_NR = 10;

    localparam byte_t RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // Standard byte k = 4c + r sits at block index 15 - 4r - c, so column c
    // is made of indices 15-c, 11-c, 7-c, 3-c; row 0 lands in word byte 3.
    function automatic word_t col_of(input block_t b, input int c);
        word_t w;
        w[3] = b[15 - c];
        w[2] = b[11 - c];
        w[1] = b[7 - c];
        w[0] = b[3 - c];
        return w;
    endfunction

    function automatic block_t block_of(input word_t w0, input word_t w1,
                                        input word_t w2, input word_t w3);
        block_t b;
        for (int r = 0; r < 4; r++) begin
            b[15 - 4*r]     = w0[3 - r];
            b[15 - 4*r - 1] = w1[3 - r];
            b[15 - 4*r - 2] = w2[3 - r];
            b[15 - 4*r - 3] = w3[3 - r];
        end
        return b;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: combinational 256-entry table lookup.
// Ports:
//   a : input byte
//   s : substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t a,
    output byte_t s
);

    // Element 0 is the leftmost byte of the concatenation.
    localparam logic [0:255][7:0] SBOX_TABLE = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign s = SBOX_TABLE[a];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule feeding the encrypt stage.
// A start pulse in IDLE latches the cipher key as round key 0; the following
// ten clocks each produce one round key into an 11-entry register file.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : begin expansion of key (only looked at in IDLE)
//   key        : cipher key, byte k = 4c + r at index 15 - 4r - c
//   rk_idx     : round-key read index 0..10
//   rk         : round key rk_idx (combinational), zero for rk_idx > 10
//   busy       : expansion in progress
//   done       : one-cycle pulse in the cycle round key 10 becomes readable
//   keys_valid : all 11 round keys belong to the most recent key
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR       = AES_NR,
    parameter int NK_BYTES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NK_BYTES-1:0][7:0]  key,
    input  logic [3:0]                rk_idx,
    output logic [NK_BYTES-1:0][7:0]  rk,
    output logic                      busy,
    output logic                      done,
    output logic                      keys_valid
);

    state_t      state_q, state_d;
    logic [3:0]  round_q, round_d;
    logic        done_q, done_d;
    logic        kv_q, kv_d;
    logic        load_key;
    logic        gen_step;

    word_t       w_q [4];
    block_t      rk_q [0:NR];

    word_t       rot_w;
    word_t       sub_w;
    word_t       t_w;
    byte_t       rcon;
    word_t       nw0, nw1, nw2, nw3;

    // RotWord then SubWord on w3; the single 4-byte S-box path.
    assign rot_w = {w_q[3][2], w_q[3][1], w_q[3][0], w_q[3][3]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .a (rot_w[g]),
            .s (sub_w[g])
        );
    end

    // round_q never exceeds NR while generating; the guard keeps the
    // constant table lookup in range for every encoding of the counter.
    assign rcon = (round_q <= 4'(NR)) ? RCON[round_q] : 8'h00;
    assign t_w  = sub_w ^ {rcon, 24'h000000};

    assign nw0 = w_q[0] ^ t_w;
    assign nw1 = w_q[1] ^ nw0;
    assign nw2 = w_q[2] ^ nw1;
    assign nw3 = w_q[3] ^ nw2;

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        done_d   = 1'b0;
        kv_d     = kv_q;
        load_key = 1'b0;
        gen_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_key = 1'b1;
                    round_d  = 4'd1;
                    kv_d     = 1'b0;
                    state_d  = GEN;
                end
            end
            GEN: begin
                gen_step = 1'b1;
                round_d  = round_q + 4'd1;
                if (round_q == 4'(NR)) begin
                    round_d = 4'd0;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                w_q[i] <= '0;
            end
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
            if (load_key) begin
                rk_q[0] <= key;
                for (int c = 0; c < 4; c++) begin
                    w_q[c] <= col_of(key, c);
                end
            end
            if (gen_step) begin
                rk_q[round_q] <= block_of(nw0, nw1, nw2, nw3);
                w_q[0]        <= nw0;
                w_q[1]        <= nw1;
                w_q[2]        <= nw2;
                w_q[3]        <= nw3;
            end
        end
    end

    assign rk         = (rk_idx <= 4'(NR)) ? rk_q[rk_idx] : '0;
    assign busy       = (state_q == GEN);
    assign done       = done_q;
    assign keys_valid = kv_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Testbench for aes_key_expand: known-answer table, randomized keys checked
// against a FIPS-style word-recursion model, and multi-cycle corner sequences.
module tb_aes_key_expand;
    import aes_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    block_t     key;
    logic [3:0] rk_idx;
    block_t     rk;
    logic       busy;
    logic       done;
    logic       keys_valid;

    always #5 clk = ~clk;

    aes_key_expand dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- counters / scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [127:0] exp_q[$];

    typedef struct {
        logic [127:0] key_std;
        int           idx;
        logic [127:0] exp_std;
        string        name;
    } vec_t;
    vec_t vecs[$];

    // ---------------- reference model ----------------
    byte_t        sbox_tab [256];
    logic [127:0] model_rk [11];

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p = 8'h00;
        byte_t x = a;
        byte_t y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic byte_t rotl8(input byte_t b, input int n);
        return byte_t'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    function automatic void build_sbox();
        for (int x = 0; x < 256; x++) begin
            byte_t inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int j = 0; j < 254; j++) inv = gmul(inv, byte_t'(x));
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    // Standard byte stream (byte 0 in the top bits) to the port packing.
    function automatic block_t pack_std(input logic [127:0] s);
        block_t b;
        for (int k = 0; k < 16; k++) begin
            b[15 - 4*(k % 4) - (k / 4)] = s[127 - 8*k -: 8];
        end
        return b;
    endfunction

    function automatic void model_expand(input logic [127:0] key_std);
        logic [31:0] w [44];
        logic [31:0] temp;
        byte_t       rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key_std[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_tab[temp[31:24]], sbox_tab[temp[23:16]],
                        sbox_tab[temp[15:8]],  sbox_tab[temp[7:0]]};
                temp = temp ^ {rc, 24'h000000};
                rc   = xtime(rc);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) begin
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endfunction

    // ---------------- checkers ----------------
    task automatic check_blk(input string name, input block_t act, input block_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic read_rk(input int idx, output block_t v);
        rk_idx = 4'(idx);
        #1;
        v = rk;
    endtask

    // Drives start for exactly one edge (E0); returns 1ns after E0.
    task automatic start_exp(input block_t k);
        key   = k;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen; bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_exp(input block_t k, input string tag);
        int n;
        start_exp(k);
        wait_done(n);
        check_val({tag, "_done_latency"}, n, 10);
        check_bit({tag, "_keys_valid"}, keys_valid, 1'b1);
    endtask

    task automatic add_vec(input logic [127:0] k, input int idx,
                           input logic [127:0] e, input string name);
        vec_t v;
        v.key_std = k;
        v.idx     = idx;
        v.exp_std = e;
        v.name    = name;
        vecs.push_back(v);
    endtask

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // ---------------- main test ----------------
    initial begin
        block_t       v;
        block_t       acc;
        logic [127:0] prev_key;
        logic [127:0] rand_key;
        logic [127:0] exp_v;
        int           n;
        int           busy_cnt;
        int           done_cnt;
        logic         b10, d10, b11;

        reset  = 1'b1;
        start  = 1'b0;
        key    = '0;
        rk_idx = 4'd0;
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_bit("reset_keys_valid", keys_valid, 1'b0);
        read_rk(0, v);
        check_blk("reset_rk0", v, '0);
        reset = 1'b0;

        // Known-answer table.
        add_vec(128'h0, 0,  128'h0,    "zero_rk0");
        add_vec(128'h0, 1,  ZERO_RK1,  "zero_rk1");
        add_vec(128'h0, 10, ZERO_RK10, "zero_rk10");
        add_vec(FIPS_KEY, 0,  FIPS_KEY,  "fips_rk0");
        add_vec(FIPS_KEY, 1,  FIPS_RK1,  "fips_rk1");
        add_vec(FIPS_KEY, 10, FIPS_RK10, "fips_rk10");
        for (int i = 11; i < 16; i++) add_vec(FIPS_KEY, i, 128'h0, $sformatf("fips_idx%0d_zero", i));

        prev_key = 128'h0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].key_std !== prev_key) begin
                run_exp(pack_std(vecs[i].key_std), vecs[i].name);
                prev_key = vecs[i].key_std;
            end
            read_rk(vecs[i].idx, v);
            check_blk(vecs[i].name, v, pack_std(vecs[i].exp_std));
        end

        // Randomized keys against the model, through the expected queue.
        for (int t = 0; t < 4; t++) begin
            rand_key = {$urandom, $urandom, $urandom, $urandom};
            model_expand(rand_key);
            for (int r = 0; r < 11; r++) exp_q.push_back(model_rk[r]);
            run_exp(pack_std(rand_key), $sformatf("rand%0d", t));
            for (int r = 0; r < 11; r++) begin
                exp_v = exp_q.pop_front();
                read_rk(r, v);
                check_blk($sformatf("rand%0d_rk%0d", t, r), v, pack_std(exp_v));
            end
        end

        // start held high for 15 edges: one expansion, then a restart on the
        // first IDLE edge.
        @(posedge clk);
        #1;
        key      = pack_std(FIPS_KEY);
        start    = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        b10 = 1'b0; d10 = 1'b0; b11 = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (c <= 9)  busy_cnt += int'(busy);
            if (c <= 10) done_cnt += int'(done);
            if (c == 10) begin b10 = busy; d10 = done; end
            if (c == 11) b11 = busy;
        end
        start = 1'b0;
        check_val("held_busy_cycles", busy_cnt, 10);
        check_val("held_done_pulses", done_cnt, 1);
        check_bit("held_busy_after_e10", b10, 1'b0);
        check_bit("held_done_at_e10", d10, 1'b1);
        check_bit("held_restart_busy", b11, 1'b1);
        wait_done(n);
        check_val("held_second_done", n, 7);
        read_rk(10, v);
        check_blk("held_rk10", v, pack_std(FIPS_RK10));

        // Reset during GEN round 5.
        @(posedge clk);
        #1;
        start_exp(pack_std(FIPS_KEY));
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_bit("midgen_busy", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        check_bit("abort_keys_valid", keys_valid, 1'b0);
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            read_rk(i, v);
            acc = acc | v;
        end
        check_blk("abort_rk_all_zero", acc, '0);
        reset = 1'b0;
        run_exp(pack_std(FIPS_KEY), "after_abort");
        read_rk(10, v);
        check_blk("after_abort_rk10", v, pack_std(FIPS_RK10));

        // New key while keys_valid=1; key input scrambled during GEN.
        rand_key = {$urandom, $urandom, $urandom, $urandom};
        model_expand(rand_key);
        check_bit("restart_kv_before", keys_valid, 1'b1);
        start_exp(pack_std(rand_key));
        check_bit("restart_kv_falls", keys_valid, 1'b0);
        check_bit("restart_busy", busy, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            n++;
        end
        check_val("restart_done_latency", n, 10);
        check_bit("restart_kv_rises", keys_valid, 1'b1);
        for (int r = 0; r < 11; r++) begin
            read_rk(r, v);
            check_blk($sformatf("restart_rk%0d", r), v, pack_std(model_rk[r]));
        end

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
